// File: rtl/accumulator_sequencer.sv
// Byte-serial instruction sequencer driving the 8-bit adder/accumulator control word.
// Optional HLT instruction enabled by defining SEQ_HALT_EN.
module accumulator_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] imm,
  output logic       bus_imm,
  output logic       nLa,
  output logic       nLb,
  output logic       Ea,
  output logic       Eu,
  output logic       sub,
  output logic       out_stb,
  output logic       busy,
  output logic       halted,
  output logic       illegal
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;

  localparam logic [OPW-1:0] OP_NOP = 4'h0;
  localparam logic [OPW-1:0] OP_LDA = 4'h1;
  localparam logic [OPW-1:0] OP_ADD = 4'h2;
  localparam logic [OPW-1:0] OP_SUB = 4'h3;
  localparam logic [OPW-1:0] OP_OUT = 4'h4;
  localparam logic [OPW-1:0] OP_CLR = 4'h5;
`ifdef SEQ_HALT_EN
  localparam logic [OPW-1:0] OP_HLT = 4'hF;
`endif

  typedef enum logic [2:0] {FETCH, OPND, EX1, EX2, HALT} state_t;

  typedef struct packed {
    logic in_ready;
    logic busy;
    logic bus_imm;
    logic nla;
    logic nlb;
    logic ea;
    logic eu;
    logic sub;
    logic out_stb;
  } ctrl_t;

  state_t         state;
  logic [OPW-1:0] ir;
  logic [DW-1:0]  imm_q;
  logic           illegal_q;
  ctrl_t          ctrl;
  logic [OPW-1:0] op_in;

  assign op_in = in_data[7:4];

  // State entered after an opcode is accepted in FETCH.
  function automatic state_t fetch_next(input logic [OPW-1:0] op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB: fetch_next = OPND;
`ifdef SEQ_HALT_EN
      OP_HLT:                 fetch_next = HALT;
`endif
      default:                fetch_next = EX1;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [OPW-1:0] op);
    case (op)
      OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_CLR: op_illegal = 1'b0;
`ifdef SEQ_HALT_EN
      OP_HLT:                                         op_illegal = 1'b0;
`endif
      default:                                        op_illegal = 1'b1;
    endcase
  endfunction

  // Control word to present while in state s executing opcode op.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [OPW-1:0] op);
    ctrl_t c;
    c      = '0;
    c.nla  = 1'b1;
    c.nlb  = 1'b1;
    c.busy = 1'b1;
    case (s)
      FETCH: begin
        c.in_ready = 1'b1;
        c.busy     = 1'b0;
      end
      OPND: c.in_ready = 1'b1;
      EX1: begin
        case (op)
          OP_LDA, OP_CLR: begin
            c.bus_imm = 1'b1;
            c.nla     = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            c.bus_imm = 1'b1;
            c.nlb     = 1'b0;
            c.sub     = (op == OP_SUB);
          end
          OP_OUT: begin
            c.ea      = 1'b1;
            c.out_stb = 1'b1;
          end
          default: ;
        endcase
      end
      EX2: begin
        c.eu  = 1'b1;
        c.nla = 1'b0;
        c.sub = (op == OP_SUB);
      end
      default: ;
    endcase
    return c;
  endfunction

  // Sequencer: control word is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      ir        <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      ctrl      <= ctrl_of(FETCH, OP_NOP);
    end else begin
      case (state)
        FETCH: if (in_valid) begin
          ir    <= op_in;
          state <= fetch_next(op_in);
          ctrl  <= ctrl_of(fetch_next(op_in), op_in);
          if (op_illegal(op_in)) illegal_q <= 1'b1;
          if (op_in == OP_CLR)   imm_q     <= '0;
        end
        OPND: if (in_valid) begin
          imm_q <= in_data;
          state <= EX1;
          ctrl  <= ctrl_of(EX1, ir);
        end
        EX1: begin
          if (ir == OP_ADD || ir == OP_SUB) begin
            state <= EX2;
            ctrl  <= ctrl_of(EX2, ir);
          end else begin
            state <= FETCH;
            ctrl  <= ctrl_of(FETCH, ir);
          end
        end
        EX2: begin
          state <= FETCH;
          ctrl  <= ctrl_of(FETCH, ir);
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_HALT_EN
  logic halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      halted_q <= 1'b0;
    else if (state == FETCH && in_valid && op_in == OP_HLT) halted_q <= 1'b1;
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign in_ready = ctrl.in_ready;
  assign busy     = ctrl.busy;
  assign bus_imm  = ctrl.bus_imm;
  assign nLa      = ctrl.nla;
  assign nLb      = ctrl.nlb;
  assign Ea       = ctrl.ea;
  assign Eu       = ctrl.eu;
  assign sub      = ctrl.sub;
  assign out_stb  = ctrl.out_stb;
  assign imm      = imm_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer: vector table plus gap, reset and HLT sequences.
module tb_accumulator_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] imm;
  logic       bus_imm, nLa, nLb, Ea, Eu, sub, out_stb, busy, halted, illegal;

  int tests = 0;
  int fails = 0;

  accumulator_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imm(imm), .bus_imm(bus_imm), .nLa(nLa), .nLb(nLb),
    .Ea(Ea), .Eu(Eu), .sub(sub), .out_stb(out_stb), .busy(busy),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Control word bits: {bus_imm, nLa, nLb, Ea, Eu, sub, out_stb}
  localparam logic [6:0] W_IDLE = 7'b0110000;

  typedef struct {
    logic [7:0] op;
    logic [7:0] opnd;
    bit         has_opnd;
    bit         two;
    logic [6:0] ex1;
    logic [6:0] ex2;
    logic [7:0] imm;
    bit         ill;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [6:0] word();
    return {bus_imm, nLa, nLb, Ea, Eu, sub, out_stb};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string name);
    chk({name, ".fetch"}, 16'({word(), in_ready, busy, halted}), 16'({W_IDLE, 3'b100}));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    chk_fetch({n, ".pre"});
    in_valid = 1'b1;
    in_data  = v.op;
    step();
    if (v.has_opnd) begin
      chk({n, ".opnd"}, 16'({word(), in_ready, busy}), 16'({W_IDLE, 2'b11}));
      in_data = v.opnd;
      step();
    end
    in_valid = 1'b0;
    chk({n, ".ex1"}, 16'({word(), in_ready, busy}), 16'({v.ex1, 2'b01}));
    chk({n, ".imm"}, 16'(imm), 16'(v.imm));
    chk({n, ".ill"}, 16'(illegal), 16'(v.ill));
    step();
    if (v.two) begin
      chk({n, ".ex2"}, 16'({word(), in_ready, busy}), 16'({v.ex2, 2'b01}));
      step();
    end
    chk_fetch(n);
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'h25, 1, 0, 7'b1010000, W_IDLE,     8'h25, 0}; // LDA
    vecs[1] = '{8'h20, 8'h03, 1, 1, 7'b1100000, 7'b0010100, 8'h03, 0}; // ADD
    vecs[2] = '{8'h3C, 8'h01, 1, 1, 7'b1100010, 7'b0010110, 8'h01, 0}; // SUB, low nibble ignored
    vecs[3] = '{8'h00, 8'hxx, 0, 0, W_IDLE,     W_IDLE,     8'h01, 0}; // NOP holds imm
    vecs[4] = '{8'h40, 8'hxx, 0, 0, 7'b0111001, W_IDLE,     8'h01, 0}; // OUT
    vecs[5] = '{8'h5F, 8'hxx, 0, 0, 7'b1010000, W_IDLE,     8'h00, 0}; // CLR
    vecs[6] = '{8'h70, 8'hxx, 0, 0, W_IDLE,     W_IDLE,     8'h00, 1}; // illegal
    vecs[7] = '{8'h40, 8'hxx, 0, 0, 7'b0111001, W_IDLE,     8'h00, 1}; // OUT, sticky illegal

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    chk("reset.out", 16'({word(), in_ready, busy, halted, illegal}), 16'({W_IDLE, 4'b1000}));
    chk("reset.imm", 16'(imm), 16'h0000);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // SUB with a 5-cycle operand gap
    in_valid = 1'b1;
    in_data  = 8'h30;
    step();
    in_valid = 1'b0;
    in_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("gap%0d", i), 16'({word(), in_ready, busy}), 16'({W_IDLE, 2'b11}));
      step();
    end
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_valid = 1'b0;
    chk("gap.ex1", 16'({word(), imm}), 16'({7'b1100010, 8'h01}));
    step();
    chk("gap.ex2", 16'(word()), 16'(7'b0010110));
    step();
    chk_fetch("gap");

    // Reset during EX2 of ADD
    in_valid = 1'b1;
    in_data  = 8'h20;
    step();
    in_data  = 8'h03;
    step();
    in_valid = 1'b0;
    step();
    chk("rst_ex2.pre", 16'(word()), 16'(7'b0010100));
    rst_n = 1'b0;
    #1;
    chk("rst_ex2.out", 16'({nLa, Eu, in_ready, busy, illegal}), 16'(5'b10100));
    chk("rst_ex2.word", 16'(word()), 16'(W_IDLE));
    chk("rst_ex2.imm", 16'(imm), 16'h0000);
    #10;
    rst_n = 1'b1;
    step();
    chk_fetch("rst_ex2.post");

    // Opcode 0xF
    in_valid = 1'b1;
    in_data  = 8'hF0;
    step();
`ifdef SEQ_HALT_EN
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_data  = 8'h10;
      chk($sformatf("halt%0d", i), 16'({word(), in_ready, halted}), 16'({W_IDLE, 2'b01}));
      step();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("halt.rst", 16'({in_ready, halted, busy}), 16'(3'b100));
    #10;
    rst_n = 1'b1;
    step();
    chk_fetch("halt.post");
`else
    in_valid = 1'b0;
    chk("hlt.ex1", 16'({word(), illegal, halted, busy}), 16'({W_IDLE, 3'b101}));
    step();
    chk_fetch("hlt");
    chk("hlt.ill", 16'(illegal), 16'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Exec strobes are mutually exclusive on the bus
  always @(negedge clk) begin
    if (rst_n && (32'(bus_imm) + 32'(Ea) + 32'(Eu)) > 1) begin
      tests++;
      fails++;
      $display("FAIL bus_excl: bus_imm=%b Ea=%b Eu=%b at %0t", bus_imm, Ea, Eu, $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not finish, limit 100000 reached");
    $fatal(1, "timeout");
  end

endmodule
